// File: rtl/instr_fetch_responder_pkg.sv
// Shared CPU definitions for the instruction fetch path.
// Holds the default widths and the response buffer occupancy encoding.
package instr_fetch_responder_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int DEPTH_DEF   = 256;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] occ_entries(input logic [1:0] occ);
    case (occ)
      OCC_ONE:  return 2'd1;
      OCC_FULL: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry fall-through response buffer. An arriving entry is shown combinationally when the buffer is empty.
// No added latency; head_ready low parks arrivals, and the caller must never push into a full buffer without a pop.
module fetch_skid_buffer
  import instr_fetch_responder_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push_valid,
  input  logic [ADDR_W-1:0]  push_addr,
  input  logic [INSTR_W-1:0] push_instr,
  output logic               head_valid,
  output logic [ADDR_W-1:0]  head_addr,
  output logic [INSTR_W-1:0] head_instr,
  input  logic               head_ready,
  output logic [1:0]         occ
);

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [1:0] occ_q;
  entry_t     ent0;
  entry_t     ent1;
  entry_t     push_ent;

  assign push_ent   = {push_addr, push_instr};
  assign occ        = occ_q;
  assign head_valid = (occ_q != OCC_EMPTY) || push_valid;
  assign {head_addr, head_instr} = (occ_q != OCC_EMPTY) ? ent0 : push_ent;

  // ent0 is always the head; ent1 shifts down on a pop from FULL.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (push_valid && !head_ready) begin
            ent0  <= push_ent;
            occ_q <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (head_ready) begin
            if (push_valid) ent0 <= push_ent;
            else            occ_q <= OCC_EMPTY;
          end else if (push_valid) begin
            ent1  <= push_ent;
            occ_q <= OCC_FULL;
          end
        end
        OCC_FULL: begin
          if (head_ready) begin
            ent0 <= ent1;
            if (push_valid) ent1 <= push_ent;
            else            occ_q <= OCC_ONE;
          end
        end
        default: occ_q <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: program memory with a one-cycle synchronous read feeding a 2-entry response buffer.
// Latency 1; req_ready drops once buffered + in-flight reaches 2, so rsp_ready stalls never overflow the buffer.
module instr_fetch_responder
  import instr_fetch_responder_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               req_ready,
  input  logic               flush,
  output logic               rsp_valid,
  output logic [INSTR_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0]  rsp_addr,
  input  logic               rsp_ready,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic [INSTR_W-1:0] rd_data;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_valid;
  logic               req_fire;
  logic [1:0]         occ;
  logic [1:0]         pending;
  logic               head_valid;
  logic [INSTR_W-1:0] head_instr;
  logic [ADDR_W-1:0]  head_addr;

  // Truncation gives the modulo-DEPTH wrap for power-of-two depths.
  assign rd_idx = IDX_W'(req_addr);
  assign wr_idx = IDX_W'(wr_addr);

  assign pending   = occ_entries(occ) + {1'b0, rd_valid};
  assign req_ready = !rst && !flush && (pending < 2'd2);
  assign req_fire  = req_valid && req_ready;

  // No reset here: program contents survive rst, and the read register sits
  // beside the write so a same-address collision returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en)    mem[wr_idx] <= wr_data;
    if (req_fire) rd_data     <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_addr  <= '0;
    end else begin
      rd_valid <= req_fire;
      if (req_fire) rd_addr <= req_addr;
    end
  end

  fetch_skid_buffer #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (rd_valid),
    .push_addr  (rd_addr),
    .push_instr (rd_data),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .head_instr (head_instr),
    .head_ready (rsp_ready),
    .occ        (occ)
  );

  assign rsp_valid = !rst && head_valid;
  assign rsp_instr = rst ? '0 : head_instr;
  assign rsp_addr  = rst ? '0 : head_addr;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder with a per-cycle queue-based reference model.
module tb_instr_fetch_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [7:0]  req_addr = '0;
  logic        req_ready;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic [15:0] rsp_instr;
  logic [7:0]  rsp_addr;
  logic        rsp_ready = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;

  logic        s_req_valid = 1'b0;
  logic [7:0]  s_req_addr = '0;
  logic        s_req_ready;
  logic        s_flush = 1'b0;
  logic        s_rsp_valid;
  logic [15:0] s_rsp_instr;
  logic [7:0]  s_rsp_addr;
  logic        s_rsp_ready = 1'b1;

  always #5 clk = ~clk;

  instr_fetch_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_addr(rsp_addr),
    .rsp_ready(rsp_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  instr_fetch_responder #(.ADDR_W(8), .INSTR_W(16), .DEPTH(16)) dut16 (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_addr(s_req_addr), .req_ready(s_req_ready),
    .flush(s_flush), .rsp_valid(s_rsp_valid), .rsp_instr(s_rsp_instr), .rsp_addr(s_rsp_addr),
    .rsp_ready(s_rsp_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Reference: every accepted, not yet consumed fetch sits in q, visible from the cycle after acceptance.
  typedef struct {
    logic [7:0]  addr;
    logic [15:0] instr;
    int          stamp;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mm [256];
  logic        exp_ready;
  logic        exp_valid;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      exp_ready = !rst && !flush && (q.size() < 2);
      exp_valid = !rst && (q.size() > 0) && (q[0].stamp < cyc);
      check("model_req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
      check("model_rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        check("model_rsp_addr", {24'b0, rsp_addr}, {24'b0, q[0].addr});
        check("model_rsp_instr", {16'b0, rsp_instr}, {16'b0, q[0].instr});
      end
      if (rst) begin
        check("model_rst_addr", {24'b0, rsp_addr}, 32'h0);
        check("model_rst_instr", {16'b0, rsp_instr}, 32'h0);
      end
      if (rst || flush) begin
        q.delete();
      end else begin
        if (exp_valid && rsp_ready) void'(q.pop_front());
        if (req_valid && exp_ready) begin
          e.addr  = req_addr;
          e.instr = mm[int'(req_addr) % 256];
          e.stamp = cyc;
          q.push_back(e);
        end
      end
      if (wr_en) mm[int'(wr_addr) % 256] = wr_data;
    end
  end

  logic [7:0]  ld_addr [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5};
  logic [15:0] ld_data [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

  initial begin
    // Program load happens while rst is held: writes must still land.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = ld_addr[i]; wr_data = ld_data[i];
      @(negedge clk);
      if (i == 0) begin
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_req_ready", {31'b0, req_ready}, 32'h0);
      end
      nxt();
    end
    wr_en = 1'b0;

    // Back-to-back fetches of 0..3.
    rst = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 8'd0;
    @(negedge clk); check("s1_ready_after_rst", {31'b0, req_ready}, 32'h1);
    nxt(); req_addr = 8'd1;
    @(negedge clk); check("s1_rsp0", {rsp_valid, 7'b0, rsp_addr, rsp_instr}, 32'h8000_1111);
    nxt(); req_addr = 8'd2;
    @(negedge clk); check("s1_rsp1", {rsp_valid, 7'b0, rsp_addr, rsp_instr}, 32'h8001_2222);
    nxt(); req_addr = 8'd3;
    @(negedge clk); check("s1_rsp2", {rsp_valid, 7'b0, rsp_addr, rsp_instr}, 32'h8002_3333);
    nxt(); req_valid = 1'b0;
    @(negedge clk); check("s1_rsp3", {rsp_valid, 7'b0, rsp_addr, rsp_instr}, 32'h8003_4444);
    nxt();
    @(negedge clk); check("s1_idle", {31'b0, rsp_valid}, 32'h0);

    // Backpressure: third request waits until the buffer drains.
    nxt(); rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'd0;
    @(negedge clk); check("s2_acc0", {31'b0, req_ready}, 32'h1);
    nxt(); req_addr = 8'd1;
    @(negedge clk); check("s2_acc1", {31'b0, req_ready}, 32'h1);
    nxt(); req_addr = 8'd2;
    @(negedge clk); check("s2_blocked", {31'b0, req_ready}, 32'h0);
    check("s2_hold_a", {16'b0, rsp_instr}, 32'h1111);
    nxt();
    @(negedge clk); check("s2_hold_b", {rsp_valid, req_ready, 14'b0, rsp_instr}, 32'h8000_1111);
    nxt(); rsp_ready = 1'b1;
    @(negedge clk); check("s2_pop0", {rsp_valid, req_ready, 14'b0, rsp_instr}, 32'h8000_1111);
    nxt();
    @(negedge clk); check("s2_pop1", {rsp_valid, req_ready, 14'b0, rsp_instr}, 32'hC000_2222);
    nxt(); req_valid = 1'b0;
    @(negedge clk); check("s2_rsp2", {rsp_valid, 7'b0, rsp_addr, rsp_instr}, 32'h8002_3333);
    nxt();
    @(negedge clk); check("s2_idle", {31'b0, rsp_valid}, 32'h0);

    // Flush with a full buffer, coinciding with a pop.
    nxt(); rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'd0;
    nxt(); req_addr = 8'd1;
    nxt(); req_valid = 1'b0;
    nxt(); flush = 1'b1; rsp_ready = 1'b1;
    @(negedge clk); check("s3_flush_ready", {rsp_valid, req_ready}, 32'h2);
    nxt(); flush = 1'b0; req_valid = 1'b1; req_addr = 8'd3;
    @(negedge clk); check("s3_after_flush", {rsp_valid, req_ready}, 32'h1);
    nxt(); req_valid = 1'b0;
    @(negedge clk); check("s3_no_stale", {rsp_valid, 7'b0, rsp_addr, rsp_instr}, 32'h8003_4444);
    nxt();
    @(negedge clk); check("s3_idle", {31'b0, rsp_valid}, 32'h0);

    // Same-cycle write and read of address 5.
    nxt(); wr_en = 1'b1; wr_addr = 8'd5; wr_data = 16'hBEEF; req_valid = 1'b1; req_addr = 8'd5;
    nxt(); wr_en = 1'b0;
    @(negedge clk); check("s4_old_data", {rsp_valid, 7'b0, rsp_addr, rsp_instr}, 32'h8005_5555);
    nxt(); req_valid = 1'b0;
    @(negedge clk); check("s4_new_data", {rsp_valid, 7'b0, rsp_addr, rsp_instr}, 32'h8005_BEEF);
    nxt();

    // Reset with two fetches pending.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'd0;
    nxt(); req_addr = 8'd1;
    nxt(); req_valid = 1'b0;
    @(negedge clk); check("s5_pending", {rsp_valid, req_ready}, 32'h2);
    nxt(); rst = 1'b1;
    @(negedge clk); check("s5_in_rst", {rsp_valid, req_ready, 6'b0, rsp_addr, rsp_instr}, 32'h0);
    nxt(); rst = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 8'd0;
    @(negedge clk); check("s5_after_rst", {rsp_valid, req_ready}, 32'h1);
    nxt(); req_valid = 1'b0;
    @(negedge clk); check("s5_mem_kept", {rsp_valid, 7'b0, rsp_addr, rsp_instr}, 32'h8000_1111);
    nxt();

    // DEPTH=16 instance: 0x12 wraps to word 2.
    s_req_valid = 1'b1; s_req_addr = 8'h12;
    @(negedge clk); check("s6_ready", {31'b0, s_req_ready}, 32'h1);
    nxt(); s_req_valid = 1'b0;
    @(negedge clk); check("s6_wrap", {s_rsp_valid, 7'b0, s_rsp_addr, s_rsp_instr}, 32'h8012_3333);
    nxt();
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
